rv_muldiv: RTL and testbench
============================

Name: rv_muldiv

Overview:
- Iterative multiply/divide unit for the RV32M instructions MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU.
- Sits beside the single-cycle ALU and receives the same decoded operands, rs1 and rs2.
- The core holds the pipeline while busy is high and writes rd back on the done pulse.
- Algorithms: radix-2 shift-add for multiply, restoring shift-subtract for divide, one bit per clock.

Parameters:
- XLEN, 32, operand/result width. Only 32 is supported; the iteration counter is $clog2(XLEN)+1 bits.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  request; sampled only in IDLE
- funct3  in  3  M-extension op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1  in  32  operand A / dividend
- rs2  in  32  operand B / divisor
- kill  in  1  abort the current operation (flush)
- rd  out  32  result; held until the next accepted start
- busy  out  1  high from the cycle after acceptance until done
- done  out  1  one-cycle pulse, rd valid in the same cycle

Behaviour:
- Reset: synchronous, applied when rst_n=0 at the clock edge.
  - Reset values: state=IDLE, rd=0, busy=0, done=0, all internal registers 0.
  - Reset mid-operation abandons the operation with no done pulse.
- States:
  - IDLE: if start=1, latch funct3, rs1 and rs2.
    - Special cases go to FIN directly.
    - Otherwise go to CALC with count=0.
    - For the signed ops, latch absolute values and a result-sign flag.
  - CALC: one iteration per cycle. After 32 iterations (count==31) go to FIN.
  - FIN: done=1, rd is driven with the final value, busy=0 next cycle, return to IDLE.
- Latency: start accepted at edge N gives done at N+33 for normal ops, and at N+1 for special cases. A back-to-back start is accepted in the cycle after done.
- busy=1 in CALC and FIN; done=1 only in FIN.
- start while busy is ignored. Inputs are not re-sampled mid-operation.
- Multiply:
  - Operand signedness by op:
    - MUL/MULHU: both operands unsigned.
    - MULH: both signed.
    - MULHSU: rs1 signed, rs2 unsigned.
  - Form a 64-bit unsigned product of the magnitudes, then negate it (two's complement) if the sign flag is set.
  - MUL returns product[31:0]; MULH, MULHSU and MULHU return product[63:32].
- Divide:
  - DIV/REM use signed magnitudes; DIVU/REMU use unsigned.
  - Quotient sign = sign(rs1) xor sign(rs2); remainder sign = sign(rs1).
  - Negation is applied in the FIN transition.
- Special cases (no CALC, done at N+1):
  - Divisor==0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give rs1 unchanged.
  - Signed overflow, rs1=0x80000000 with rs2=0xFFFFFFFF: DIV gives 0x80000000; REM gives 0.
- kill:
  - In CALC or FIN it forces IDLE next edge: busy=0, done suppressed, rd unchanged.
  - In IDLE it has priority over start, so the request is not accepted.
- Arithmetic wraps modulo 2^64 internally. No exceptions or flags are produced.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD -> done at N+33, rd=0xFFFFFFEB, busy high for 33 cycles.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU 100/0 -> 0xFFFFFFFF and REMU 100/0 -> 100, both done at N+1. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 at N+1; REM same operands -> 0.
- start during CALC with different operands -> ignored, first result intact. kill at N+10 -> no done, busy=0 at N+11, then a new MUL 3x5 -> 15.
- rst_n=0 for one edge mid-CALC -> busy=0, done=0, rd=0 next cycle, no stale done afterwards.

Source files
------------

// File: rtl/rv_muldiv.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide, one bit per clock, with single-cycle handling of divide special cases.
module rv_muldiv #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            kill,
  output logic [XLEN-1:0] rd,
  output logic            busy,
  output logic            done
);

  localparam int unsigned CW = $clog2(XLEN) + 1;
  localparam int unsigned DW = 2 * XLEN;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN} state_e;

  state_e          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [DW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            neg_q, neg_d;
  logic [XLEN-1:0] rd_q, rd_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  // Operand decode for a request presented in IDLE
  logic            is_mul_c, sgn1_c, sgn2_c, neg1_c, neg2_c, div0_c, ovf_c;
  logic [XLEN-1:0] mag1_c, mag2_c;

  assign is_mul_c = ~funct3[2];
  assign sgn1_c   = is_mul_c ? (funct3[1:0] == 2'b01 || funct3[1:0] == 2'b10) : ~funct3[0];
  assign sgn2_c   = is_mul_c ? (funct3[1:0] == 2'b01) : ~funct3[0];
  assign neg1_c   = sgn1_c & rs1[XLEN-1];
  assign neg2_c   = sgn2_c & rs2[XLEN-1];
  assign mag1_c   = neg1_c ? -rs1 : rs1;
  assign mag2_c   = neg2_c ? -rs2 : rs2;
  assign div0_c   = ~is_mul_c & (rs2 == '0);
  assign ovf_c    = ~is_mul_c & ~funct3[0] & (rs1 == {1'b1, {(XLEN-1){1'b0}}}) & (rs2 == '1);

  // One iteration: acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  logic [XLEN:0]   sum_c;
  logic [XLEN:0]   rem_sh_c;
  logic [XLEN-1:0] diff_c;
  logic            ge_c;
  logic [DW-1:0]   acc_nxt_c;
  logic [DW-1:0]   prod_fin_c;
  logic [XLEN-1:0] div_val_c;
  logic [XLEN-1:0] result_c;

  always_comb begin
    sum_c      = {1'b0, acc_q[DW-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : '0);
    rem_sh_c   = acc_q[DW-1:XLEN-1];
    ge_c       = rem_sh_c >= {1'b0, a_q};
    diff_c     = rem_sh_c[XLEN-1:0] - a_q;
    acc_nxt_c  = acc_q;
    if (!op_q[2]) begin
      acc_nxt_c = {sum_c, acc_q[XLEN-1:1]};
    end else if (ge_c) begin
      acc_nxt_c = {diff_c, acc_q[XLEN-2:0], 1'b1};
    end else begin
      acc_nxt_c = {rem_sh_c[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end
    prod_fin_c = neg_q ? -acc_nxt_c : acc_nxt_c;
    div_val_c  = op_q[1] ? acc_nxt_c[DW-1:XLEN] : acc_nxt_c[XLEN-1:0];
    if (!op_q[2]) begin
      result_c = (op_q[1:0] == 2'b00) ? prod_fin_c[XLEN-1:0] : prod_fin_c[DW-1:XLEN];
    end else begin
      result_c = neg_q ? -div_val_c : div_val_c;
    end
  end

  // Next-state and register update logic
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    rd_d    = rd_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !kill) begin
          op_d   = funct3;
          busy_d = 1'b1;
          if (div0_c) begin
            rd_d    = funct3[1] ? rs1 : '1;
            done_d  = 1'b1;
            state_d = S_FIN;
          end else if (ovf_c) begin
            rd_d    = funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
            done_d  = 1'b1;
            state_d = S_FIN;
          end else begin
            a_d     = is_mul_c ? mag1_c : mag2_c;
            acc_d   = {{XLEN{1'b0}}, (is_mul_c ? mag2_c : mag1_c)};
            neg_d   = (is_mul_c || !funct3[1]) ? (neg1_c ^ neg2_c) : neg1_c;
            cnt_d   = '0;
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (kill) begin
          state_d = S_IDLE;
        end else begin
          acc_d  = acc_nxt_c;
          cnt_d  = cnt_q + CW'(1);
          busy_d = 1'b1;
          if (cnt_q == CW'(XLEN - 1)) begin
            rd_d    = result_c;
            done_d  = 1'b1;
            state_d = S_FIN;
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      rd_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      rd_q    <= rd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign rd   = rd_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_rv_muldiv.sv
// Self-checking bench for rv_muldiv: cycle-level protocol model with an
// arithmetic reference, directed literal cases, then randomized traffic.
module tb_rv_muldiv;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        kill = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] rs1 = 32'd0;
  logic [31:0] rs2 = 32'd0;
  logic [31:0] rd;
  logic        busy;
  logic        done;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  rv_muldiv #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
    .rs1(rs1), .rs2(rs2), .kill(kill), .rd(rd), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Architectural result of one RV32M instruction
  function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    int ia, ib;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    ia = a;
    ib = b;
    case (f)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(ia / ib);
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(ia % ib);
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return f[2] && (b == 32'd0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Protocol model: countdown of remaining busy cycles after acceptance
  int          m_left = 0;
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic [31:0] m_rd = 32'd0;
  logic [31:0] m_res = 32'd0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_left = 0; m_busy = 1'b0; m_done = 1'b0; m_rd = 32'd0;
    end else if (m_left > 0) begin
      if (kill) begin
        m_left = 0; m_busy = 1'b0; m_done = 1'b0;
      end else begin
        m_left = m_left - 1;
        m_busy = (m_left > 0);
        m_done = (m_left == 1);
        if (m_left == 1) m_rd = m_res;
      end
    end else begin
      m_busy = 1'b0;
      m_done = 1'b0;
      if (start && !kill) begin
        m_res  = ref_res(funct3, rs1, rs2);
        m_left = is_special(funct3, rs1, rs2) ? 1 : 33;
        m_busy = 1'b1;
        m_done = (m_left == 1);
        if (m_left == 1) m_rd = m_res;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if ({busy, done, rd} !== {m_busy, m_done, m_rd}) begin
        failures++;
        $display("FAIL cycle@%0t busy/done/rd got %b/%b/%h want %b/%b/%h",
                 $time, busy, done, rd, m_busy, m_done, m_rd);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got %h want %h", name, got, exp);
    end
  endtask

  // Issue one op in the cycle after the caller's current one, wait for done
  task automatic do_op(input string name, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int lat);
    int cnt;
    @(negedge clk);
    funct3 = f; rs1 = a; rs2 = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 1;
    while (!done && cnt < 60) begin
      @(negedge clk);
      cnt++;
    end
    check({name, " rd"}, rd, exp);
    check({name, " latency"}, 32'(cnt), 32'(lat));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 6)
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom % 16);
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    int cnt;
    bit saw_done;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset rd", rd, 32'd0);
    rst_n = 1'b1;

    do_op("MUL", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    do_op("MULH", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
    do_op("MULHU", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    do_op("MULHSU", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
    do_op("DIV", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    do_op("REM", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    do_op("DIVU", 3'd5, 32'd100, 32'd7, 32'd14, 33);
    do_op("REMU", 3'd7, 32'd100, 32'd7, 32'd2, 33);
    do_op("DIVU0", 3'd5, 32'd100, 32'd0, 32'hFFFF_FFFF, 1);
    do_op("REMU0", 3'd7, 32'd100, 32'd0, 32'd100, 1);
    do_op("DIVOVF", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    do_op("REMOVF", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

    // A second start while busy must not disturb the running DIVU
    @(negedge clk);
    funct3 = 3'd5; rs1 = 32'd100; rs2 = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 1;
    while (!done && cnt < 60) begin
      if (cnt == 5) begin funct3 = 3'd0; rs1 = 32'd9; rs2 = 32'd9; start = 1'b1; end
      else start = 1'b0;
      @(negedge clk);
      cnt++;
    end
    start = 1'b0;
    check("ignored start rd", rd, 32'd14);
    check("ignored start latency", 32'(cnt), 32'd33);

    // kill sampled at edge N+10
    @(negedge clk);
    funct3 = 3'd0; rs1 = 32'd11; rs2 = 32'd13; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check("kill busy", 32'(busy), 32'd0);
    check("kill done", 32'(done), 32'd0);
    check("kill rd held", rd, 32'd14);
    do_op("MUL after kill", 3'd0, 32'd3, 32'd5, 32'd15, 33);

    // Synchronous reset mid-CALC
    @(negedge clk);
    funct3 = 3'd1; rs1 = 32'h1234_5678; rs2 = 32'h9ABC_DEF0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midreset busy", 32'(busy), 32'd0);
    check("midreset done", 32'(done), 32'd0);
    check("midreset rd", rd, 32'd0);
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("no stale done", 32'(saw_done), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      start  = ($urandom % 3 == 0);
      kill   = ($urandom % 150 == 0);
      rst_n  = ($urandom % 700 != 0);
      funct3 = 3'($urandom);
      rs1    = pick();
      rs2    = pick();
    end
    @(negedge clk);
    start = 1'b0; kill = 1'b0; rst_n = 1'b1;
    repeat (40) @(negedge clk);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
